// File: rtl/cdc_hs_rx_pkg.sv
// Shared definitions for the target-side 4-phase req/ack receiver:
// FSM encodings and the default request synchronizer depth.
package cdc_hs_rx_pkg;

    typedef enum logic {
        CDC_HS_IDLE  = 1'b0,
        CDC_HS_ACKED = 1'b1
    } cdc_hs_state_e;

    localparam int CDC_HS_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_bit_n.sv
// N-stage single-bit level synchronizer with synchronous active-high reset.
// Reusable on either side of a req/ack crossing.
module sync_bit_n
    import cdc_hs_rx_pkg::*;
#(
    parameter int STAGES = CDC_HS_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[STAGES-2:0], d};
        end
    end

    assign q = sync_p[STAGES-1];

endmodule

// File: rtl/cdc_hs_rx.sv
// Target-domain responder for a 4-phase req/ack crossing: synchronizes req,
// captures the held data word into a one-entry buffer and offers it on valid/ready.
module cdc_hs_rx
    import cdc_hs_rx_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = CDC_HS_SYNC_STAGES
) (
    input  logic              clk_target,
    input  logic              rst,
    input  logic              req_async,
    input  logic [DATA_W-1:0] data_async,
    output logic              ack,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy
);

    cdc_hs_state_e state, state_nxt;
    logic          req_s;
    logic          buf_free;
    logic          capture;

    sync_bit_n #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk_target),
        .rst (rst),
        .d   (req_async),
        .q   (req_s)
    );

    // A word leaving this very cycle frees the slot for a same-edge capture.
    assign buf_free = !out_valid || out_ready;
    assign capture  = (state == CDC_HS_IDLE) && req_s && buf_free;

    always_comb begin
        state_nxt = state;
        case (state)
            CDC_HS_IDLE:  if (capture) state_nxt = CDC_HS_ACKED;
            CDC_HS_ACKED: if (!req_s)  state_nxt = CDC_HS_IDLE;
            default:      state_nxt = CDC_HS_IDLE;
        endcase
    end

    always_ff @(posedge clk_target) begin
        if (rst) begin
            state <= CDC_HS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // data_async is only sampled while req_s is high, when the source holds it stable.
    always_ff @(posedge clk_target) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= data_async;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign ack  = (state == CDC_HS_ACKED);
    assign busy = (state != CDC_HS_IDLE) || out_valid;

endmodule
